// File: rtl/miriscv_mdu_seq.sv
// Sequential RISC-V M-extension unit: radix-2 multiply and
// restoring divide sharing one (XLEN+1)-bit adder.
module miriscv_mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            mdu_req_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] mdu_port_a_i,
  input  logic [XLEN-1:0] mdu_port_b_i,
  input  logic            mdu_kill_i,
  output logic            mdu_stall_req_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int AW = XLEN + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              a_sgn_en, b_sgn_en;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;

  logic [AW-1:0]     add_a, add_b, sum;
  logic              add_c;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   q_neg, r_neg;
  logic [XLEN-1:0]   res_sel;

  // Operand conditioning: signedness, magnitudes, special divides
  always_comb begin
    a_sgn_en = 1'b0;
    b_sgn_en = 1'b0;
    unique case (mdu_op_i)
      3'd1, 3'd4, 3'd6: begin
        a_sgn_en = 1'b1;
        b_sgn_en = 1'b1;
      end
      3'd2:    a_sgn_en = 1'b1;
      default: ;
    endcase
    a_neg    = a_sgn_en & mdu_port_a_i[XLEN-1];
    b_neg    = b_sgn_en & mdu_port_b_i[XLEN-1];
    a_mag    = a_neg ? -mdu_port_a_i : mdu_port_a_i;
    b_mag    = b_neg ? -mdu_port_b_i : mdu_port_b_i;
    div_zero = mdu_op_i[2] & (mdu_port_b_i == '0);
    div_ovf  = mdu_op_i[2] & ~mdu_op_i[0]
             & (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}})
             & (&mdu_port_b_i);
  end

  // Shared adder: add for multiply, subtract for divide
  always_comb begin
    if (op_q[2]) begin
      add_a = {hi_q, lo_q[XLEN-1]};
      add_b = ~{1'b0, m_q};
      add_c = 1'b1;
    end else begin
      add_a = {1'b0, hi_q};
      add_b = lo_q[0] ? {1'b0, m_q} : '0;
      add_c = 1'b0;
    end
    sum      = add_a + add_b + AW'(add_c);
    prod_neg = -{hi_q, lo_q};
    q_neg    = -lo_q;
    r_neg    = -hi_q;
    res_sel  = ((op_q == 3'd0) || (op_q[2:1] == 2'b10))
             ? lo_q : hi_q;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (mdu_req_i && !mdu_kill_i) begin
          op_d  = mdu_op_i;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          if (div_zero) begin
            lo_d    = '1;
            hi_d    = mdu_port_a_i;
            state_d = DONE;
          end else if (div_ovf) begin
            lo_d    = mdu_port_a_i;
            hi_d    = '0;
            state_d = DONE;
          end else if (mdu_op_i[2]) begin
            hi_d    = '0;
            lo_d    = a_mag;
            m_d     = b_mag;
            state_d = CALC;
          end else begin
            hi_d    = '0;
            lo_d    = b_mag;
            m_d     = a_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (mdu_kill_i) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            hi_d = sum[XLEN] ? add_a[XLEN-1:0]
                             : sum[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~sum[XLEN]};
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (mdu_kill_i) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            if (sa_q ^ sb_q) lo_d = q_neg;
            if (sa_q)        hi_d = r_neg;
          end else if (sa_q ^ sb_q) begin
            {hi_d, lo_d} = prod_neg;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!mdu_kill_i) begin
          valid_d = 1'b1;
          res_d   = res_sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign mdu_valid_o     = valid_q;
  assign mdu_result_o    = res_q;
  assign mdu_stall_req_o = mdu_req_i & ~valid_q;

endmodule

// File: tb/tb_miriscv_mdu_seq.sv
// Scoreboard bench for miriscv_mdu_seq: directed corner cases,
// kill/reset aborts and random operations against a reference model.
module tb_miriscv_mdu_seq;

  logic        clk = 1'b0;
  logic        arstn;
  logic        req;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        stall;
  logic        valid;
  logic [31:0] result;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  miriscv_mdu_seq #(.XLEN(32)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .mdu_req_i       (req),
    .mdu_op_i        (op),
    .mdu_port_a_i    (a),
    .mdu_port_b_i    (b),
    .mdu_kill_i      (kill),
    .mdu_stall_req_o (stall),
    .mdu_valid_o     (valid),
    .mdu_result_o    (result)
  );

  function automatic logic [31:0] model(
    input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic [63:0] up;
    int q;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin
        up = {32'b0, x} * {32'b0, y};
        return up[63:32];
      end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        q = int'(x) / int'(y);
        return $unsigned(q);
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        q = int'(x) % int'(y);
        return $unsigned(q);
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: stall relation every cycle, pop scoreboard on valid
  always @(negedge clk) begin
    checks++;
    if (stall !== (req & ~valid)) begin
      failures++;
      $display("FAIL stall t=%0d got=%b exp=%b",
               cyc, stall, req & ~valid);
    end
    if (valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL spurious_valid t=%0d got=1 exp=0", cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (result !== mon_e.res) begin
          failures++;
          $display("FAIL result op=%0d got=%h exp=%h",
                   mon_e.op, result, mon_e.res);
        end
        checks++;
        if (cyc != mon_e.due) begin
          failures++;
          $display("FAIL latency op=%0d got=%0d exp=%0d",
                   mon_e.op, cyc, mon_e.due);
        end
      end
    end
  end

  // Called just after a falling edge with the DUT idle
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    exp_t e;
    bit   sp;
    int   n;
    req  = 1'b1;
    op   = o;
    a    = x;
    b    = y;
    sp   = o[2] && ((y == 0) ||
           (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    e.res = model(o, x, y);
    e.op  = o;
    e.due = cyc + 1 + (sp ? 1 : 34);
    sbq.push_back(e);
    @(negedge clk);
    #1;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL timeout op=%0d got=none exp=valid", o);
      sbq.delete();
    end
    #1;
  endtask

  initial begin
    arstn = 1'b0;
    req   = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    kill  = 1'b0;
    repeat (3) @(negedge clk);
    #1 arstn = 1'b1;
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'h8000_0000, 32'h8000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd7, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Kill in the 10th CALC cycle, then hold kill over idle requests
    req = 1'b1;
    op  = 3'd3;
    a   = $urandom;
    b   = $urandom;
    repeat (10) @(negedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    chk("kill_valid", {31'b0, valid}, 32'h0);
    repeat (3) @(negedge clk);
    #1 kill = 1'b0;
    issue(3'd1, 32'hFFFF_FFF0, 32'h0000_1234);

    // Asynchronous reset mid-operation
    req = 1'b1;
    op  = 3'd5;
    a   = $urandom;
    b   = 32'd13;
    repeat (20) @(negedge clk);
    #1 arstn = 1'b0;
    #1;
    chk("arst_valid", {31'b0, valid}, 32'h0);
    chk("arst_result", result, 32'h0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    #1 arstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_arst_result", result, 32'h0);
    #1;

    for (int i = 0; i < 50; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
      end
    end

    req = 1'b0;
    repeat (40) @(negedge clk);
    chk("pending", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
